// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants, FSM state type and clog2 helper for the UART receiver
package uart_pkg;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } rx_state_t;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// rtl/uart_rx_sampler.sv - rx synchroniser, falling-edge detect, tick counter and 3-sample majority vote
module uart_rx_sampler
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = 16
)
(
   input  logic clk,
   input  logic rst_n,
   input  logic rx,
   input  logic i_clr,
   output logic o_sample_strobe,
   output logic o_bit_value,
   output logic o_start_edge
);

   localparam int TW  = clog2(OVERSAMPLE);
   localparam int MID = OVERSAMPLE / 2;
   localparam logic [TW-1:0] T_WRAP = TW'(OVERSAMPLE - 1);
   localparam logic [TW-1:0] T_S0   = TW'(MID - 1);
   localparam logic [TW-1:0] T_S1   = TW'(MID);
   localparam logic [TW-1:0] T_S2   = TW'(MID + 1);

   logic [1:0]    r_sync;
   logic          r_prev;
   logic [TW-1:0] r_tick;
   logic          r_s0;
   logic          r_s1;
   logic          w_rx;

   assign w_rx            = r_sync[1];
   assign o_start_edge    = r_prev & ~w_rx;
   assign o_sample_strobe = (r_tick == T_S2);
   assign o_bit_value     = (r_s0 & r_s1) | (r_s0 & w_rx) | (r_s1 & w_rx);

   // Two-flop synchroniser plus one history flop; idle-high so reset needs a real falling edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync <= 2'b11;
         r_prev <= 1'b1;
      end else begin
         r_sync <= {r_sync[0], rx};
         r_prev <= w_rx;
      end
   end

   // Tick counter: held at 0 while the FSM idles, otherwise wraps every bit period
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tick <= '0;
      end else if (i_clr || r_tick == T_WRAP) begin
         r_tick <= '0;
      end else begin
         r_tick <= r_tick + TW'(1);
      end
   end

   // Capture the first two of the three mid-bit samples; the third is live at the strobe tick
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s0 <= 1'b1;
         r_s1 <= 1'b1;
      end else begin
         if (r_tick == T_S0) r_s0 <= w_rx;
         if (r_tick == T_S1) r_s1 <= w_rx;
      end
   end

endmodule

// File: rtl/uart_rx_frame.sv
// rtl/uart_rx_frame.sv - UART frame receiver with valid/ready output; idle timeout under UART_RX_TIMEOUT_EN
module uart_rx_frame
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE   = 16,
   parameter int DATA_BITS    = 8,
   parameter int FRAME_BYTES  = 2,
   parameter int PARITY       = 0,
   parameter int TIMEOUT_BITS = 32
)
(
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             rx,
   output logic [FRAME_BYTES*DATA_BITS-1:0] frame_data,
   output logic                             frame_valid,
   input  logic                             frame_ready,
   output logic                             frame_err,
   output logic                             overrun,
   output logic                             timeout_err
);

   localparam int FW = FRAME_BYTES * DATA_BITS;
   localparam int CW = clog2(FRAME_BYTES + 1);
   localparam int BW = clog2(DATA_BITS + 1);

   rx_state_t      r_state;
   rx_state_t      w_state_next;
   logic           w_strobe;
   logic           w_bit;
   logic           w_edge;
   logic [DATA_BITS-1:0] r_shift;
   logic [BW-1:0]  r_bit_cnt;
   logic [CW-1:0]  r_cnt;
   logic [FW-1:0]  r_buf;
   logic [FW-1:0]  w_assembled;
   logic           r_par_bad;
   logic           w_last_bit;
   logic           w_stop_eval;
   logic           w_char_ok;
   logic           w_complete;
   logic           w_accept;
   logic           w_timeout;

   uart_rx_sampler #(.OVERSAMPLE(OVERSAMPLE)) u_sampler (
      .clk             (clk),
      .rst_n           (rst_n),
      .rx              (rx),
      .i_clr           (w_state_next == ST_IDLE),
      .o_sample_strobe (w_strobe),
      .o_bit_value     (w_bit),
      .o_start_edge    (w_edge)
   );

   assign w_last_bit  = (r_bit_cnt == BW'(DATA_BITS - 1));
   assign w_stop_eval = (r_state == ST_STOP) && w_strobe;
   assign w_char_ok   = w_stop_eval && w_bit && !r_par_bad;
   assign w_complete  = w_char_ok && (r_cnt == CW'(FRAME_BYTES - 1));
   assign w_accept    = frame_valid && frame_ready;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_next;
   end

   // Next-state logic; every decision waits for the majority-vote strobe
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:   if (w_edge) w_state_next = ST_START;
         ST_START:  if (w_strobe) w_state_next = w_bit ? ST_IDLE : ST_DATA;
         ST_DATA:   if (w_strobe && w_last_bit)
                       w_state_next = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
         ST_PARITY: if (w_strobe) w_state_next = ST_STOP;
         ST_STOP:   if (w_strobe) w_state_next = ST_IDLE;
         default:   w_state_next = ST_IDLE;
      endcase
   end

   // Drop the just-received character into its slot of the partial frame
   always_comb begin
      w_assembled = r_buf;
      w_assembled[r_cnt*DATA_BITS +: DATA_BITS] = r_shift;
   end

   // Character datapath: shift register, parity check, slot counter, error pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shift   <= '0;
         r_bit_cnt <= '0;
         r_par_bad <= 1'b0;
         r_cnt     <= '0;
         r_buf     <= '0;
         frame_err <= 1'b0;
      end else begin
         frame_err <= w_stop_eval && !(w_bit && !r_par_bad);
         if (r_state == ST_START) begin
            r_bit_cnt <= '0;
            r_par_bad <= 1'b0;
         end
         if (r_state == ST_DATA && w_strobe) begin
            r_shift   <= {w_bit, r_shift[DATA_BITS-1:1]};
            r_bit_cnt <= r_bit_cnt + BW'(1);
         end
         if (r_state == ST_PARITY && w_strobe)
            r_par_bad <= ((^r_shift) ^ w_bit) != (PARITY == PAR_ODD);
         if (w_timeout || (w_stop_eval && !w_char_ok)) begin
            r_cnt <= '0;
         end else if (w_char_ok) begin
            r_buf <= w_assembled;
            r_cnt <= w_complete ? '0 : r_cnt + CW'(1);
         end
      end
   end

   // Output handshake: a frame completing while the previous one is still pending is dropped
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_data  <= '0;
         frame_valid <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         if (w_complete && (!frame_valid || frame_ready)) begin
            frame_data  <= w_assembled;
            frame_valid <= 1'b1;
         end else if (w_accept) begin
            frame_valid <= 1'b0;
         end
         if (w_complete && frame_valid && !frame_ready) overrun <= 1'b1;
         else if (w_accept)                              overrun <= 1'b0;
      end
   end

`ifdef UART_RX_TIMEOUT_EN
   localparam int TOW = clog2(TIMEOUT_BITS + 1);
   localparam int OSW = clog2(OVERSAMPLE);

   logic [OSW-1:0] r_idle_tick;
   logic [TOW-1:0] r_idle_bits;
   logic           r_timeout_err;

   assign w_timeout = (r_state == ST_IDLE) && (r_cnt != '0) && !w_edge &&
                      (r_idle_tick == OSW'(OVERSAMPLE - 1)) &&
                      (r_idle_bits == TOW'(TIMEOUT_BITS - 1));
   assign timeout_err = r_timeout_err;

   // Count idle bit periods while a partial frame is pending
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idle_tick   <= '0;
         r_idle_bits   <= '0;
         r_timeout_err <= 1'b0;
      end else begin
         r_timeout_err <= w_timeout;
         if (r_state != ST_IDLE || r_cnt == '0 || w_edge) begin
            r_idle_tick <= '0;
            r_idle_bits <= '0;
         end else if (r_idle_tick == OSW'(OVERSAMPLE - 1)) begin
            r_idle_tick <= '0;
            r_idle_bits <= r_idle_bits + TOW'(1);
         end else begin
            r_idle_tick <= r_idle_tick + OSW'(1);
         end
      end
   end
`else
   assign w_timeout   = 1'b0;
   assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb/tb_uart_rx_frame.sv - directed bench for uart_rx_frame (default and even-parity instances)
module tb_uart_rx_frame;

   logic        clk;
   logic        rst_n;
   logic        rx;
   logic        rx_p;
   logic        rdy;
   logic        rdy_p;
   logic [15:0] frame_data;
   logic        frame_valid;
   logic        frame_err;
   logic        overrun;
   logic        timeout_err;
   logic [15:0] frame_data_p;
   logic        frame_valid_p;
   logic        frame_err_p;
   logic        overrun_p;
   logic        timeout_err_p;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          hs_cnt  = 0;
   int          err_cnt = 0;
   int          to_cnt  = 0;
   int          hs_cnt_p  = 0;
   int          err_cnt_p = 0;
   int          cyc     = 0;
   int          to_cyc  = 0;
   logic [15:0] hs_data   = '0;
   logic [15:0] hs_data_p = '0;

   uart_rx_frame dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .rx          (rx),
      .frame_data  (frame_data),
      .frame_valid (frame_valid),
      .frame_ready (rdy),
      .frame_err   (frame_err),
      .overrun     (overrun),
      .timeout_err (timeout_err)
   );

   uart_rx_frame #(.PARITY(2)) dut_p (
      .clk         (clk),
      .rst_n       (rst_n),
      .rx          (rx_p),
      .frame_data  (frame_data_p),
      .frame_valid (frame_valid_p),
      .frame_ready (rdy_p),
      .frame_err   (frame_err_p),
      .overrun     (overrun_p),
      .timeout_err (timeout_err_p)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (frame_valid && rdy) begin
         hs_cnt++;
         hs_data = frame_data;
      end
      if (frame_err) err_cnt++;
      if (timeout_err) begin
         to_cnt++;
         to_cyc = cyc;
      end
      if (frame_valid_p && rdy_p) begin
         hs_cnt_p++;
         hs_data_p = frame_data_p;
      end
      if (frame_err_p) err_cnt_p++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_bit(input int sel, input logic b, input int noise_idx);
      for (int i = 0; i < 16; i++) begin
         if (sel == 0) rx   = (i == noise_idx) ? ~b : b;
         else          rx_p = (i == noise_idx) ? ~b : b;
         @(negedge clk);
      end
   endtask

   task automatic send_char(input int sel, input logic [7:0] d, input bit use_par,
                            input bit par, input bit stop, input bit noisy);
      int   total;
      logic b;
      total = use_par ? 11 : 10;
      for (int j = 0; j < total; j++) begin
         if (j == 0)                      b = 1'b0;
         else if (j <= 8)                 b = d[j-1];
         else if (use_par && j == 9)      b = par;
         else                             b = stop;
         send_bit(sel, b, noisy ? 7 + (j % 3) : -1);
      end
      for (int i = 0; i < 4; i++) begin
         if (sel == 0) rx = 1'b1;
         else          rx_p = 1'b1;
         @(negedge clk);
      end
   endtask

   task automatic set_rdy(input logic v);
      @(posedge clk);
      #1 rdy = v;
      @(negedge clk);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int hs0, err0, hs0_p, err0_p, t0;
      rx = 1'b1; rx_p = 1'b1; rdy = 1'b1; rdy_p = 1'b1; rst_n = 1'b0;
      repeat (4) @(negedge clk);
      chk("reset_valid", frame_valid, 0);
      chk("reset_data", frame_data, 0);
      chk("reset_err", frame_err, 0);
      chk("reset_overrun", overrun, 0);
      chk("reset_timeout", timeout_err, 0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // basic frame, ready held high
      hs0 = hs_cnt; err0 = err_cnt;
      send_char(0, 8'h5A, 0, 0, 1, 0);
      send_char(0, 8'hC3, 0, 0, 1, 0);
      chk("basic_hs_count", hs_cnt - hs0, 1);
      chk("basic_data", hs_data, 16'hC35A);
      chk("basic_err", err_cnt - err0, 0);
      chk("basic_overrun", overrun, 0);
      chk("basic_valid_drop", frame_valid, 0);

      // overrun with ready held low
      set_rdy(1'b0);
      hs0 = hs_cnt;
      send_char(0, 8'h55, 0, 0, 1, 0);
      send_char(0, 8'hAA, 0, 0, 1, 0);
      chk("ovr_first_valid", frame_valid, 1);
      chk("ovr_first_overrun", overrun, 0);
      send_char(0, 8'h34, 0, 0, 1, 0);
      send_char(0, 8'h12, 0, 0, 1, 0);
      chk("ovr_valid", frame_valid, 1);
      chk("ovr_data_held", frame_data, 16'hAA55);
      chk("ovr_sticky", overrun, 1);
      set_rdy(1'b1);
      @(negedge clk);
      chk("ovr_valid_drop", frame_valid, 0);
      chk("ovr_cleared", overrun, 0);
      chk("ovr_hs_data", hs_data, 16'hAA55);
      chk("ovr_hs_count", hs_cnt - hs0, 1);

      // even parity instance
      hs0_p = hs_cnt_p; err0_p = err_cnt_p;
      send_char(1, 8'h5A, 1, 1, 1, 0);
      chk("par_bad_err", err_cnt_p - err0_p, 1);
      chk("par_bad_no_valid", hs_cnt_p - hs0_p, 0);
      send_char(1, 8'h01, 1, 1, 1, 0);
      send_char(1, 8'h02, 1, 1, 1, 0);
      chk("par_good_hs", hs_cnt_p - hs0_p, 1);
      chk("par_good_data", hs_data_p, 16'h0201);
      chk("par_good_no_err", err_cnt_p - err0_p, 1);

      // short glitch on idle line is a false start
      hs0 = hs_cnt; err0 = err_cnt;
      rx = 1'b0;
      repeat (4) @(negedge clk);
      rx = 1'b1;
      repeat (40) @(negedge clk);
      chk("glitch_no_err", err_cnt - err0, 0);
      chk("glitch_no_valid", hs_cnt - hs0, 0);

      // bad stop bit on second char discards the partial frame
      send_char(0, 8'h81, 0, 0, 1, 0);
      send_char(0, 8'h42, 0, 0, 0, 0);
      chk("stop_err", err_cnt - err0, 1);
      chk("stop_no_valid", hs_cnt - hs0, 0);

      // one noisy sample per bit is outvoted
      send_char(0, 8'h3C, 0, 0, 1, 1);
      send_char(0, 8'h7E, 0, 0, 1, 1);
      chk("noise_hs", hs_cnt - hs0, 1);
      chk("noise_data", hs_data, 16'h7E3C);
      chk("noise_no_err", err_cnt - err0, 1);

      // reset in the middle of the second character
      hs0 = hs_cnt; err0 = err_cnt;
      send_char(0, 8'h99, 0, 0, 1, 0);
      send_bit(0, 1'b0, -1);
      send_bit(0, 1'b1, -1);
      send_bit(0, 1'b0, -1);
      send_bit(0, 1'b1, -1);
      rst_n = 1'b0;
      rx = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_mid_valid", frame_valid, 0);
      chk("rst_mid_err", frame_err, 0);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      send_char(0, 8'h11, 0, 0, 1, 0);
      send_char(0, 8'h22, 0, 0, 1, 0);
      chk("rst_fresh_hs", hs_cnt - hs0, 1);
      chk("rst_fresh_data", hs_data, 16'h2211);
      chk("rst_fresh_no_err", err_cnt - err0, 0);
      chk("timeout_none", to_cnt, 0);

`ifdef UART_RX_TIMEOUT_EN
      send_char(0, 8'h99, 0, 0, 1, 0);
      t0 = cyc;
      repeat (40 * 16) @(negedge clk);
      chk("timeout_pulse", to_cnt, 1);
      chk("timeout_at_32_bits", ((to_cyc - t0) >= 480) && ((to_cyc - t0) <= 530), 1);
      hs0 = hs_cnt;
      send_char(0, 8'h44, 0, 0, 1, 0);
      send_char(0, 8'h55, 0, 0, 1, 0);
      chk("timeout_discard", hs_data, 16'h5544);
`else
      t0 = cyc;
      chk("timeout_tied", timeout_err, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
